// File: rtl/dsc_chunk_packer.sv
// dsc_chunk_packer: packs DSC encoder bytes into fixed-size chunks,
// zero-pads early-terminated chunks, emits little-endian keep-tagged words.
module dsc_chunk_packer #(
  parameter int OUT_BYTES = 4,
  parameter int CHUNK_W   = 16,
  parameter int NCHUNK_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHUNK_W-1:0]           cfg_chunk_size,
  input  logic [NCHUNK_W-1:0]          cfg_num_chunks,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8*OUT_BYTES-1:0]       out_data,
  output logic [OUT_BYTES-1:0]         out_keep,
  output logic                         out_last_chunk,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         done,
  output logic [CHUNK_W+NCHUNK_W-1:0]  pad_bytes
);

  localparam int LW = $clog2(OUT_BYTES);
  localparam int PW = CHUNK_W + NCHUNK_W;
  localparam int DW = 8 * OUT_BYTES;

  typedef enum logic [1:0] {IDLE, FILL, PAD, FINAL} state_t;

  state_t              state;
  logic [CHUNK_W-1:0]  chunk_size;
  logic [CHUNK_W-1:0]  byte_cnt;
  logic [NCHUNK_W-1:0] num_chunks;
  logic [NCHUNK_W-1:0] chunk_cnt;
  logic [LW-1:0]       lane;
  logic [DW-1:0]       acc;

  logic                out_free;
  logic                accept;
  logic                chunk_end;
  logic                frame_end;
  logic                word_full;
  logic [DW-1:0]       new_word;
  logic [OUT_BYTES-1:0] keep_fill;
  logic [OUT_BYTES-1:0] keep_pad;
  logic [CHUNK_W-1:0]  rem;
  logic [CHUNK_W-1:0]  room;
  logic [CHUNK_W-1:0]  pad_n;
  logic [CHUNK_W-1:0]  pad_end;
  logic                pad_done;
  logic [PW:0]         pad_sum;
  logic [PW-1:0]       pad_next;

  // The output register is free when empty or being drained this cycle
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == FILL) && out_free;
  assign accept    = in_valid && in_ready;
  assign chunk_end = (byte_cnt + CHUNK_W'(1)) == chunk_size;
  assign frame_end = chunk_cnt == (num_chunks - NCHUNK_W'(1));
  assign word_full = lane == LW'(OUT_BYTES - 1);

  // Word assembly, keep masks and pad sizing for the current lane
  always_comb begin
    new_word = acc;
    new_word[lane*8 +: 8] = in_data;
    rem     = chunk_size - byte_cnt;
    room    = CHUNK_W'(OUT_BYTES) - CHUNK_W'(lane);
    pad_n   = (room < rem) ? room : rem;
    pad_end = CHUNK_W'(lane) + pad_n;
    pad_done = (byte_cnt + pad_n) == chunk_size;
    for (int i = 0; i < OUT_BYTES; i++) begin
      keep_fill[i] = LW'(i) <= lane;
      keep_pad[i]  = CHUNK_W'(i) < pad_end;
    end
    pad_sum  = {1'b0, pad_bytes} + (PW+1)'(pad_n);
    pad_next = pad_sum[PW] ? '1 : pad_sum[PW-1:0];
  end

  // Frame FSM with registered output word and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      chunk_size     <= '0;
      num_chunks     <= '0;
      byte_cnt       <= '0;
      chunk_cnt      <= '0;
      lane           <= '0;
      acc            <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_keep       <= '0;
      out_last_chunk <= 1'b0;
      out_eof        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pad_bytes      <= '0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_chunk_size != '0 && cfg_num_chunks != '0) begin
            chunk_size <= cfg_chunk_size;
            num_chunks <= cfg_num_chunks;
            byte_cnt   <= '0;
            chunk_cnt  <= '0;
            lane       <= '0;
            acc        <= '0;
            pad_bytes  <= '0;
            busy       <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (chunk_end) begin
              out_valid      <= 1'b1;
              out_data       <= new_word;
              out_keep       <= keep_fill;
              out_last_chunk <= 1'b1;
              out_eof        <= frame_end;
              acc            <= '0;
              lane           <= '0;
              byte_cnt       <= '0;
              chunk_cnt      <= chunk_cnt + NCHUNK_W'(1);
              if (frame_end) state <= FINAL;
            end else if (word_full) begin
              out_valid      <= 1'b1;
              out_data       <= new_word;
              out_keep       <= keep_fill;
              out_last_chunk <= 1'b0;
              out_eof        <= 1'b0;
              acc            <= '0;
              lane           <= '0;
              byte_cnt       <= byte_cnt + CHUNK_W'(1);
              if (in_last) state <= PAD;
            end else begin
              acc      <= new_word;
              lane     <= lane + LW'(1);
              byte_cnt <= byte_cnt + CHUNK_W'(1);
              if (in_last) state <= PAD;
            end
          end
        end
        PAD: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_data  <= acc;
            out_keep  <= keep_pad;
            pad_bytes <= pad_next;
            acc       <= '0;
            lane      <= '0;
            if (pad_done) begin
              out_last_chunk <= 1'b1;
              out_eof        <= frame_end;
              byte_cnt       <= '0;
              chunk_cnt      <= chunk_cnt + NCHUNK_W'(1);
              state          <= frame_end ? FINAL : FILL;
            end else begin
              out_last_chunk <= 1'b0;
              out_eof        <= 1'b0;
              byte_cnt       <= byte_cnt + pad_n;
            end
          end
        end
        FINAL: begin
          if (out_valid && out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_chunk_packer.sv
// tb_dsc_chunk_packer: table-driven frames plus stall, start-ignore
// and mid-frame reset sequences for dsc_chunk_packer.
module tb_dsc_chunk_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_chunk_size;
  logic [15:0] cfg_num_chunks;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last_chunk;
  logic        out_eof;
  logic        busy;
  logic        done;
  logic [31:0] pad_bytes;

  dsc_chunk_packer #(.OUT_BYTES(4), .CHUNK_W(16), .NCHUNK_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_chunk_size(cfg_chunk_size), .cfg_num_chunks(cfg_num_chunks),
    .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep),
    .out_last_chunk(out_last_chunk), .out_eof(out_eof),
    .busy(busy), .done(done), .pad_bytes(pad_bytes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        lc;
    logic        eof;
  } word_t;

  typedef struct packed {
    logic [15:0]       cs;
    logic [15:0]       nc;
    int                nb;
    logic [11:0][7:0]  b;
    logic [11:0]       lst;
    int                nw;
    logic [3:0][31:0]  d;
    logic [3:0][3:0]   k;
    logic [3:0]        lc;
    logic [3:0]        eof;
    logic [31:0]       pad;
  } vec_t;

  word_t got[$];
  vec_t  vt[5];
  int    n_vec = 0;
  int    n_bad = 0;
  int    stalls;

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      got.push_back('{out_data, out_keep, out_last_chunk, out_eof});

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(logic [15:0] cs, logic [15:0] nc);
    cfg_chunk_size = cs;
    cfg_num_chunks = nc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, logic l);
    logic ok;
    int   t;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalls++;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) chk("in_timeout", 64'(ok), 64'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'(1));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0] = '0;
    vt[0].cs = 6; vt[0].nc = 1; vt[0].nb = 6; vt[0].lst = 12'h020;
    for (int j = 0; j < 6; j++) vt[0].b[j] = 8'(j + 1);
    vt[0].nw = 2;
    vt[0].d[0] = 32'h04030201; vt[0].k[0] = 4'hF;
    vt[0].d[1] = 32'h00000605; vt[0].k[1] = 4'h3;
    vt[0].lc = 4'b0010; vt[0].eof = 4'b0010; vt[0].pad = 0;

    vt[1] = '0;
    vt[1].cs = 7; vt[1].nc = 1; vt[1].nb = 3; vt[1].lst = 12'h004;
    vt[1].b[0] = 8'hAA; vt[1].b[1] = 8'hBB; vt[1].b[2] = 8'hCC;
    vt[1].nw = 2;
    vt[1].d[0] = 32'h00CCBBAA; vt[1].k[0] = 4'hF;
    vt[1].d[1] = 32'h00000000; vt[1].k[1] = 4'h7;
    vt[1].lc = 4'b0010; vt[1].eof = 4'b0010; vt[1].pad = 4;

    vt[2] = '0;
    vt[2].cs = 4; vt[2].nc = 3; vt[2].nb = 12; vt[2].lst = 12'h888;
    for (int j = 0; j < 12; j++) vt[2].b[j] = 8'(8'h10 + j);
    vt[2].nw = 3;
    vt[2].d[0] = 32'h13121110; vt[2].k[0] = 4'hF;
    vt[2].d[1] = 32'h17161514; vt[2].k[1] = 4'hF;
    vt[2].d[2] = 32'h1B1A1918; vt[2].k[2] = 4'hF;
    vt[2].lc = 4'b0111; vt[2].eof = 4'b0100; vt[2].pad = 0;

    vt[3] = '0;
    vt[3].cs = 5; vt[3].nc = 2; vt[3].nb = 7; vt[3].lst = 12'h042;
    vt[3].b[0] = 8'h21; vt[3].b[1] = 8'h22;
    for (int j = 0; j < 5; j++) vt[3].b[j+2] = 8'(8'h31 + j);
    vt[3].nw = 4;
    vt[3].d[0] = 32'h00002221; vt[3].k[0] = 4'hF;
    vt[3].d[1] = 32'h00000000; vt[3].k[1] = 4'h1;
    vt[3].d[2] = 32'h34333231; vt[3].k[2] = 4'hF;
    vt[3].d[3] = 32'h00000035; vt[3].k[3] = 4'h1;
    vt[3].lc = 4'b1010; vt[3].eof = 4'b1000; vt[3].pad = 3;

    vt[4] = '0;
    vt[4].cs = 6; vt[4].nc = 1; vt[4].nb = 4; vt[4].lst = 12'h008;
    for (int j = 0; j < 4; j++) vt[4].b[j] = 8'(8'h41 + j);
    vt[4].nw = 2;
    vt[4].d[0] = 32'h44434241; vt[4].k[0] = 4'hF;
    vt[4].d[1] = 32'h00000000; vt[4].k[1] = 4'h3;
    vt[4].lc = 4'b0010; vt[4].eof = 4'b0010; vt[4].pad = 2;

    rst = 1'b1;
    cfg_chunk_size = '0;
    cfg_num_chunks = '0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_keep", 64'(out_keep), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_lc_eof", 64'({out_last_chunk, out_eof}), 64'(0));
    chk("rst_pad", 64'(pad_bytes), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      got.delete();
      stalls = 0;
      do_start(vt[v].cs, vt[v].nc);
      chk("busy_start", 64'(busy), 64'(1));
      for (int j = 0; j < vt[v].nb; j++)
        send_byte(vt[v].b[j], vt[v].lst[j]);
      wait_done();
      chk("nwords", 64'(got.size()), 64'(vt[v].nw));
      for (int j = 0; j < vt[v].nw && j < got.size(); j++) begin
        chk("data", 64'(got[j].d), 64'(vt[v].d[j]));
        chk("keep", 64'(got[j].k), 64'(vt[v].k[j]));
        chk("last_chunk", 64'(got[j].lc), 64'(vt[v].lc[j]));
        chk("eof", 64'(got[j].eof), 64'(vt[v].eof[j]));
      end
      chk("pad_bytes", 64'(pad_bytes), 64'(vt[v].pad));
      if (v == 2) chk("no_stall", 64'(stalls), 64'(0));
    end

    got.delete();
    out_ready = 1'b0;
    do_start(16'd8, 16'd1);
    fork
      begin
        for (int j = 0; j < 8; j++) send_byte(8'(8'h51 + j), j == 7);
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        for (int c = 0; c < 5; c++) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          chk("stall_data", 64'(out_data), 64'h54535251);
          chk("stall_keep", 64'(out_keep), 64'hF);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    chk("stall_nwords", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("stall_w0", 64'(got[0].d), 64'h54535251);
      chk("stall_w1", 64'(got[1].d), 64'h58575655);
      chk("stall_w1_flags", 64'({got[1].k, got[1].lc, got[1].eof}), 64'h3F);
    end

    got.delete();
    do_start(16'd0, 16'd1);
    chk("zero_cs_busy", 64'(busy), 64'(0));
    do_start(16'd4, 16'd0);
    chk("zero_nc_busy", 64'(busy), 64'(0));
    chk("zero_cfg_ready", 64'(in_ready), 64'(0));
    do_start(16'd4, 16'd1);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    do_start(16'd8, 16'd3);
    chk("restart_busy", 64'(busy), 64'(1));
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b1);
    wait_done();
    chk("restart_nwords", 64'(got.size()), 64'(1));
    if (got.size() == 1) begin
      chk("restart_w0", 64'(got[0].d), 64'h64636261);
      chk("restart_flags", 64'({got[0].k, got[0].lc, got[0].eof}), 64'h3F);
    end

    got.delete();
    do_start(16'd8, 16'd1);
    send_byte(8'h81, 1'b0);
    send_byte(8'h82, 1'b0);
    send_byte(8'h83, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_pad", 64'(pad_bytes), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_nwords", 64'(got.size()), 64'(0));
    do_start(16'd4, 16'd1);
    for (int j = 0; j < 4; j++) send_byte(8'(8'h71 + j), j == 3);
    wait_done();
    chk("fresh_nwords", 64'(got.size()), 64'(1));
    if (got.size() == 1) begin
      chk("fresh_w0", 64'(got[0].d), 64'h74737271);
      chk("fresh_flags", 64'({got[0].k, got[0].lc, got[0].eof}), 64'h3F);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
